// File: rtl/otter_fetch_pkg.sv
// Shared types and defaults for the OTTER front-end fetch queue.
package otter_fetch_pkg;

  localparam int FQ_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [31:0] pc0;
    logic [31:0] inst0;
    logic [31:0] pc1;
    logic [31:0] inst1;
    logic        v1;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and dispatch-side handshake bundle of the fetch queue.
interface fetch_queue_if #(parameter int DEPTH = 8);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          enq_valid;
  logic [31:0]   enq_pc_0;
  logic [31:0]   enq_pc_1;
  logic [31:0]   enq_inst_0;
  logic [31:0]   enq_inst_1;
  logic          enq_valid_1;
  logic          flush;
  logic          fetch_stall;
  logic          deq_valid;
  logic          deq_ready;
  logic [31:0]   deq_pc_0;
  logic [31:0]   deq_pc_1;
  logic [31:0]   deq_inst_0;
  logic [31:0]   deq_inst_1;
  logic          deq_valid_1;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output enq_valid, enq_pc_0, enq_pc_1, enq_inst_0, enq_inst_1, enq_valid_1,
    output flush, deq_ready,
    input  fetch_stall, deq_valid, deq_pc_0, deq_pc_1, deq_inst_0, deq_inst_1,
    input  deq_valid_1, count, overflow
  );

  modport slave (
    input  enq_valid, enq_pc_0, enq_pc_1, enq_inst_0, enq_inst_1, enq_valid_1,
    input  flush, deq_ready,
    output fetch_stall, deq_valid, deq_pc_0, deq_pc_1, deq_inst_0, deq_inst_1,
    output deq_valid_1, count, overflow
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// Pair storage: synchronous write, asynchronous read, contents never reset.
module fetch_queue_ram
  import otter_fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_pair_t   wdata,
  input  logic [AW-1:0] raddr,
  output fetch_pair_t   rdata
);

  fetch_pair_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Dual-slot instruction fetch queue between imem read and decode/dispatch.
module fetch_queue
  import otter_fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
  input logic         CLK,
  input logic         EXT_RESET,
  fetch_queue_if.slave fq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          deq_valid_c;
  logic          deq_fire;
  logic          enq_fire;
  logic          ovf_event;
  fetch_pair_t   wr_pair;
  fetch_pair_t   rd_pair;

  assign deq_valid_c = (count_q != '0) & ~fq.flush;
  assign deq_fire    = deq_valid_c & fq.deq_ready;
  // A dequeue in the same cycle frees the slot, so a full queue still accepts.
  assign enq_fire    = fq.enq_valid & ~fq.flush & ((count_q < CW'(DEPTH)) | deq_fire);
  assign ovf_event   = fq.enq_valid & ~fq.flush & (count_q == CW'(DEPTH)) & ~deq_fire;

  assign wr_pair = '{pc0:   fq.enq_pc_0,
                     inst0: fq.enq_inst_0,
                     pc1:   fq.enq_pc_1,
                     inst1: fq.enq_inst_1,
                     v1:    fq.enq_valid_1};

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (CLK),
    .we    (enq_fire),
    .waddr (tail),
    .wdata (wr_pair),
    .raddr (head),
    .rdata (rd_pair)
  );

  always_ff @(posedge CLK or negedge EXT_RESET) begin
    if (!EXT_RESET) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (fq.flush) begin
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
      end else begin
        if (deq_fire) head <= head + AW'(1);
        if (enq_fire) tail <= tail + AW'(1);
        case ({enq_fire, deq_fire})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
      if (ovf_event) overflow_q <= 1'b1;
    end
  end

  // Stall one entry early: the pair already in the imem read still needs a home.
  assign fq.fetch_stall = (count_q >= CW'(DEPTH - 1)) & ~fq.flush;
  assign fq.deq_valid   = deq_valid_c;
  assign fq.deq_pc_0    = rd_pair.pc0;
  assign fq.deq_inst_0  = rd_pair.inst0;
  assign fq.deq_pc_1    = rd_pair.pc1;
  assign fq.deq_inst_1  = rd_pair.inst1;
  assign fq.deq_valid_1 = rd_pair.v1;
  assign fq.count       = count_q;
  assign fq.overflow    = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue against a queue-based reference.
module tb_fetch_queue;
  import otter_fetch_pkg::*;

  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic EXT_RESET = 1'b0;
  int   total = 0;
  int   bad = 0;

  fetch_pair_t mq[$];
  logic        m_ovf = 1'b0;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH)) u_dut (
    .CLK       (CLK),
    .EXT_RESET (EXT_RESET),
    .fq        (fq)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (mq.size() != 0) && !fq.flush;
    chk("count", 32'(fq.count), 32'(mq.size()));
    chk("deq_valid", 32'(fq.deq_valid), 32'(ev));
    chk("fetch_stall", 32'(fq.fetch_stall), 32'((mq.size() >= DEPTH - 1) && !fq.flush));
    chk("overflow", 32'(fq.overflow), 32'(m_ovf));
    if (ev) begin
      chk("deq_pc_0", fq.deq_pc_0, mq[0].pc0);
      chk("deq_inst_0", fq.deq_inst_0, mq[0].inst0);
      chk("deq_pc_1", fq.deq_pc_1, mq[0].pc1);
      chk("deq_inst_1", fq.deq_inst_1, mq[0].inst1);
      chk("deq_valid_1", 32'(fq.deq_valid_1), 32'(mq[0].v1));
    end
  endtask

  task automatic model_step();
    bit          deq;
    bit          enq;
    fetch_pair_t p;
    if (fq.flush) begin
      mq.delete();
    end else begin
      deq = (mq.size() > 0) && fq.deq_ready;
      enq = fq.enq_valid && ((mq.size() < DEPTH) || deq);
      if (fq.enq_valid && !enq) m_ovf = 1'b1;
      p = '{pc0: fq.enq_pc_0, inst0: fq.enq_inst_0, pc1: fq.enq_pc_1,
            inst1: fq.enq_inst_1, v1: fq.enq_valid_1};
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(p);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] p0, input logic [31:0] i0,
                       input logic v1, input logic fl, input logic rdy);
    fq.enq_valid   = ev;
    fq.enq_pc_0    = p0;
    fq.enq_pc_1    = p0 + 32'd4;
    fq.enq_inst_0  = i0;
    fq.enq_inst_1  = ~i0;
    fq.enq_valid_1 = v1;
    fq.flush       = fl;
    fq.deq_ready   = rdy;
    #1;
    check_outputs();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    fq.enq_valid = 0; fq.enq_pc_0 = 0; fq.enq_pc_1 = 0; fq.enq_inst_0 = 0;
    fq.enq_inst_1 = 0; fq.enq_valid_1 = 0; fq.flush = 0; fq.deq_ready = 0;

    // reset state
    #12;
    chk("rst_count", 32'(fq.count), 32'd0);
    chk("rst_deq_valid", 32'(fq.deq_valid), 32'd0);
    chk("rst_stall", 32'(fq.fetch_stall), 32'd0);
    chk("rst_overflow", 32'(fq.overflow), 32'd0);
    EXT_RESET = 1'b1;
    @(posedge CLK); #1;

    // fill
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(i * 8), $urandom, 1'b1, 1'b0, 1'b0);
      if (i == DEPTH - 2) chk("fill_stall_at_7", 32'(fq.fetch_stall), 32'd1);
    end
    chk("fill_count", 32'(fq.count), 32'd8);
    chk("fill_overflow", 32'(fq.overflow), 32'd0);

    // drain in order
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_pc0", fq.deq_pc_0, 32'(i * 8));
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    end
    chk("drain_empty", 32'(fq.deq_valid), 32'd0);

    // refill then concurrent traffic at full, exercising pointer wrap
    for (int i = 0; i < DEPTH; i++) drive(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, $urandom, $urandom, 1'($urandom), 1'b0, 1'b1);
    chk("full_conc_count", 32'(fq.count), 32'd8);
    chk("full_conc_ovf", 32'(fq.overflow), 32'd0);

    // overflow
    drive(1'b1, 32'hdead_0000, $urandom, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'hdead_0008, $urandom, 1'b1, 1'b0, 1'b0);
    chk("ovf_set", 32'(fq.overflow), 32'd1);
    chk("ovf_count", 32'(fq.count), 32'd8);

    // flush at count=5 with enq and deq requested
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("pre_flush_count", 32'(fq.count), 32'd5);
    drive(1'b1, 32'h0bad_0000, $urandom, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 32'(fq.count), 32'd0);
    drive(1'b1, 32'h100, $urandom, 1'b1, 1'b0, 1'b0);
    chk("post_flush_pc0", fq.deq_pc_0, 32'h100);

    // odd-slot entry, dequeuing 0x100 in the same cycle
    drive(1'b1, 32'h44, $urandom, 1'b0, 1'b0, 1'b1);
    chk("odd_pc0", fq.deq_pc_0, 32'h44);
    chk("odd_v1", 32'(fq.deq_valid_1), 32'd0);
    chk("ovf_sticky", 32'(fq.overflow), 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom), $urandom, $urandom, 1'($urandom),
            1'($urandom_range(0, 19) == 0), 1'($urandom));

    // async reset mid-cycle at count=3
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    fq.enq_valid = 1'b0;
    #1;
    chk("pre_rst_count", 32'(fq.count), 32'd3);
    chk("pre_rst_ovf", 32'(fq.overflow), 32'd1);
    #1;
    EXT_RESET = 1'b0;
    #1;
    chk("arst_count", 32'(fq.count), 32'd0);
    chk("arst_deq_valid", 32'(fq.deq_valid), 32'd0);
    chk("arst_stall", 32'(fq.fetch_stall), 32'd0);
    chk("arst_overflow", 32'(fq.overflow), 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    #2;
    EXT_RESET = 1'b1;
    @(posedge CLK); #1;
    drive(1'b1, 32'h200, $urandom, 1'b1, 1'b0, 1'b0);
    chk("post_rst_pc0", fq.deq_pc_0, 32'h200);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
